// File: rtl/arm_mc_controller.sv
// ============================================================================
// Module   : arm_mc_controller
// Purpose  : Multicycle ARM-subset control unit. FSM sequencing of fetch,
//            decode, memory, data-processing and branch instructions with a
//            shared memory port (MemReady handshake), a 4-bit NZCV flags
//            register and a latched condition-pass bit.
// Options  : define ARM_MC_CMP_EN to execute CMP/CMN (flags only, no
//            writeback). Without it those encodings are treated as unused.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module arm_mc_controller (
   input  logic        clk,
   input  logic        reset,
   input  logic [19:0] Instr,
   input  logic [3:0]  ALUFlags,
   input  logic        MemReady,
   output logic        PCWrite,
   output logic        IRWrite,
   output logic        RegWrite,
   output logic        MemWrite,
   output logic        AdrSrc,
   output logic        ALUSrcA,
   output logic [1:0]  ALUSrcB,
   output logic [1:0]  ResultSrc,
   output logic [1:0]  ImmSrc,
   output logic [1:0]  RegSrc,
   output logic [1:0]  ALUControl
);

`ifdef ARM_MC_CMP_EN
   localparam logic CMP_EN = 1'b1;
`else
   localparam logic CMP_EN = 1'b0;
`endif

   localparam logic [1:0] ALU_ADD = 2'b00;
   localparam logic [1:0] ALU_SUB = 2'b01;
   localparam logic [1:0] ALU_AND = 2'b10;
   localparam logic [1:0] ALU_ORR = 2'b11;

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEMADR   = 4'd2,
      S_MEMREAD  = 4'd3,
      S_MEMWB    = 4'd4,
      S_MEMWRITE = 4'd5,
      S_EXECUTER = 4'd6,
      S_EXECUTEI = 4'd7,
      S_ALUWB    = 4'd8,
      S_BRANCH   = 4'd9
   } state_t;

   state_t     state_q;
   logic [3:0] flags_q;     // {N,Z,C,V}
   logic       condex_q;    // condition result sampled at the end of DECODE

   // Instruction fields (Instr holds IR bits [31:12])
   logic [3:0] cond;
   logic [1:0] op;
   logic [5:0] funct;
   logic       rd_is_pc;

   assign cond     = Instr[19:16];
   assign op       = Instr[15:14];
   assign funct    = Instr[13:8];
   assign rd_is_pc = (Instr[3:0] == 4'hF);

   // ARM condition-code evaluation against a flags snapshot
   function automatic logic cond_holds(input logic [3:0] c, input logic [3:0] f);
      logic n, z, cy, v;
      {n, z, cy, v} = f;
      case (c)
         4'h0:    return z;
         4'h1:    return ~z;
         4'h2:    return cy;
         4'h3:    return ~cy;
         4'h4:    return n;
         4'h5:    return ~n;
         4'h6:    return v;
         4'h7:    return ~v;
         4'h8:    return cy & ~z;
         4'h9:    return ~cy | z;
         4'hA:    return (n == v);
         4'hB:    return (n != v);
         4'hC:    return ~z & (n == v);
         4'hD:    return z | (n != v);
         4'hE:    return 1'b1;
         default: return 1'b0;   // 1111 never executes
      endcase
   endfunction

   logic [1:0] alu_dp;      // ALU operation for the data-processing command
   logic       dp_legal;    // command is one this controller executes
   logic       dp_nowb;     // compare forms: flags only, skip ALUWB

   // Decode the data-processing command field
   always_comb begin
      alu_dp   = ALU_ADD;
      dp_legal = 1'b0;
      dp_nowb  = 1'b0;
      case (funct[4:1])
         4'b0100: begin alu_dp = ALU_ADD; dp_legal = 1'b1; end
         4'b0010: begin alu_dp = ALU_SUB; dp_legal = 1'b1; end
         4'b0000: begin alu_dp = ALU_AND; dp_legal = 1'b1; end
         4'b1100: begin alu_dp = ALU_ORR; dp_legal = 1'b1; end
         4'b1010: begin
            alu_dp   = ALU_SUB;
            dp_legal = CMP_EN & funct[0];
            dp_nowb  = 1'b1;
         end
         4'b1011: begin
            alu_dp   = ALU_ADD;
            dp_legal = CMP_EN & funct[0];
            dp_nowb  = 1'b1;
         end
         default: ;
      endcase
   end

   // State sequencing, condition latch and flags register
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= S_FETCH;
         flags_q  <= 4'b0000;
         condex_q <= 1'b0;
      end else begin
         case (state_q)
            S_FETCH: begin
               if (MemReady) state_q <= S_DECODE;
            end
            S_DECODE: begin
               condex_q <= cond_holds(cond, flags_q);
               case (op)
                  2'b01:   state_q <= S_MEMADR;
                  2'b10:   state_q <= S_BRANCH;
                  2'b00: begin
                     if (!dp_legal)     state_q <= S_FETCH;
                     else if (funct[5]) state_q <= S_EXECUTEI;
                     else               state_q <= S_EXECUTER;
                  end
                  default: state_q <= S_FETCH;
               endcase
            end
            S_MEMADR:   state_q <= funct[0] ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD: begin
               if (MemReady) state_q <= S_MEMWB;
            end
            S_MEMWB:    state_q <= S_FETCH;
            S_MEMWRITE: begin
               if (MemReady) state_q <= S_FETCH;
            end
            S_EXECUTER, S_EXECUTEI: begin
               // Logical ops leave C and V untouched
               if (funct[0] && condex_q) begin
                  flags_q[3:2] <= ALUFlags[3:2];
                  if (alu_dp == ALU_ADD || alu_dp == ALU_SUB)
                     flags_q[1:0] <= ALUFlags[1:0];
               end
               state_q <= dp_nowb ? S_FETCH : S_ALUWB;
            end
            S_ALUWB:    state_q <= S_FETCH;
            S_BRANCH:   state_q <= S_FETCH;
            default:    state_q <= S_FETCH;
         endcase
      end
   end

   // Datapath controls decoded from the current state; write enables are
   // additionally forced low while reset is asserted
   always_comb begin
      PCWrite    = 1'b0;
      IRWrite    = 1'b0;
      RegWrite   = 1'b0;
      MemWrite   = 1'b0;
      AdrSrc     = 1'b0;
      ALUSrcA    = 1'b0;
      ALUSrcB    = 2'b00;
      ResultSrc  = 2'b00;
      ImmSrc     = 2'b00;
      RegSrc     = 2'b00;
      ALUControl = ALU_ADD;
      case (state_q)
         S_FETCH: begin
            ALUSrcA   = 1'b1;
            ALUSrcB   = 2'b10;
            ResultSrc = 2'b10;
            IRWrite   = MemReady;
            PCWrite   = MemReady;
         end
         S_DECODE: begin
            ALUSrcA = 1'b1;
            ALUSrcB = 2'b10;
         end
         S_MEMADR: begin
            ALUSrcB = 2'b01;
            ImmSrc  = 2'b01;
         end
         S_MEMREAD: begin
            AdrSrc = 1'b1;
         end
         S_MEMWB: begin
            ResultSrc = 2'b01;
            RegWrite  = condex_q;
         end
         S_MEMWRITE: begin
            AdrSrc   = 1'b1;
            RegSrc   = 2'b10;
            MemWrite = condex_q;
         end
         S_EXECUTER: begin
            ALUSrcB    = 2'b00;
            ALUControl = alu_dp;
         end
         S_EXECUTEI: begin
            ALUSrcB    = 2'b01;
            ImmSrc     = 2'b00;
            ALUControl = alu_dp;
         end
         S_ALUWB: begin
            ResultSrc = 2'b00;
            RegWrite  = condex_q;
            PCWrite   = condex_q & rd_is_pc;
         end
         S_BRANCH: begin
            RegSrc    = 2'b01;
            ALUSrcB   = 2'b01;
            ImmSrc    = 2'b10;
            ResultSrc = 2'b10;
            PCWrite   = condex_q;
         end
         default: ;
      endcase
      if (reset) begin
         PCWrite  = 1'b0;
         IRWrite  = 1'b0;
         RegWrite = 1'b0;
         MemWrite = 1'b0;
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_arm_mc_controller.sv
// ============================================================================
// Module   : tb_arm_mc_controller
// Purpose  : Scoreboard bench for arm_mc_controller. An instruction-level
//            reference model expands each instruction into its expected
//            per-cycle control vectors; a negedge monitor compares them.
//            Honours ARM_MC_CMP_EN the same way as the design.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_arm_mc_controller;

`ifdef ARM_MC_CMP_EN
   localparam logic CMP_EN = 1'b1;
`else
   localparam logic CMP_EN = 1'b0;
`endif

   // Field masks within the packed control vector
   localparam logic [15:0] M_EN   = 16'hF000;
   localparam logic [15:0] M_ADR  = 16'h0800;
   localparam logic [15:0] M_SRCA = 16'h0400;
   localparam logic [15:0] M_SRCB = 16'h0300;
   localparam logic [15:0] M_RES  = 16'h00C0;
   localparam logic [15:0] M_IMM  = 16'h0030;
   localparam logic [15:0] M_REG1 = 16'h0008;
   localparam logic [15:0] M_REG0 = 16'h0004;
   localparam logic [15:0] M_ALU  = 16'h0003;

   logic        clk = 1'b0;
   logic        reset;
   logic [19:0] Instr;
   logic [3:0]  ALUFlags;
   logic        MemReady;
   logic        PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc, ALUSrcA;
   logic [1:0]  ALUSrcB, ResultSrc, ImmSrc, RegSrc, ALUControl;
   logic [15:0] act;

   always #5 clk = ~clk;

   arm_mc_controller dut (
      .clk        (clk),
      .reset      (reset),
      .Instr      (Instr),
      .ALUFlags   (ALUFlags),
      .MemReady   (MemReady),
      .PCWrite    (PCWrite),
      .IRWrite    (IRWrite),
      .RegWrite   (RegWrite),
      .MemWrite   (MemWrite),
      .AdrSrc     (AdrSrc),
      .ALUSrcA    (ALUSrcA),
      .ALUSrcB    (ALUSrcB),
      .ResultSrc  (ResultSrc),
      .ImmSrc     (ImmSrc),
      .RegSrc     (RegSrc),
      .ALUControl (ALUControl)
   );

   assign act = {PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc, ALUSrcA,
                 ALUSrcB, ResultSrc, ImmSrc, RegSrc, ALUControl};

   logic [31:0] sb_q[$];      // {expected, mask}
   string       nm_q[$];
   int          vectors     = 0;
   int          miscompares = 0;
   logic [3:0]  m_flags;      // reference NZCV

   // Monitor: compare each presented cycle against the oldest expectation
   always @(negedge clk) begin : monitor
      logic [31:0] e;
      string       nm;
      if (sb_q.size() > 0) begin
         e  = sb_q.pop_front();
         nm = nm_q.pop_front();
         vectors++;
         if (((act ^ e[31:16]) & e[15:0]) !== 16'h0000) begin
            miscompares++;
            $display("FAIL %s @%0t: got %04h want %04h (mask %04h)",
                     nm, $time, act & e[15:0], e[31:16] & e[15:0], e[15:0]);
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   function automatic logic [15:0] v(input logic pcw, input logic irw,
                                     input logic rw, input logic mw,
                                     input logic adr, input logic srca,
                                     input logic [1:0] srcb, input logic [1:0] res,
                                     input logic [1:0] imm, input logic [1:0] regs,
                                     input logic [1:0] aluc);
      return {pcw, irw, rw, mw, adr, srca, srcb, res, imm, regs, aluc};
   endfunction

   // ARM rule: pairs of codes, the odd one is the negation of the even one
   function automatic logic cond_ok(input logic [3:0] c, input logic [3:0] f);
      logic n, z, cf, vf, base;
      {n, z, cf, vf} = f;
      case (c[3:1])
         3'd0:    base = z;
         3'd1:    base = cf;
         3'd2:    base = n;
         3'd3:    base = vf;
         3'd4:    base = cf & ~z;
         3'd5:    base = (n == vf);
         3'd6:    base = ~z & (n == vf);
         default: base = 1'b1;
      endcase
      if (c == 4'hF) return 1'b0;
      if (c == 4'hE) return 1'b1;
      return c[0] ? ~base : base;
   endfunction

   function automatic logic [3:0] r4();
      return 4'($urandom);
   endfunction

   function automatic logic rb();
      return 1'($urandom);
   endfunction

   // Apply one cycle of stimulus and queue its expected response
   task automatic emit(input logic rst, input logic mr, input logic [3:0] alu,
                       input logic [19:0] ins, input logic [15:0] exp,
                       input logic [15:0] mask, input string nm);
      @(posedge clk);
      #1;
      reset    = rst;
      MemReady = mr;
      ALUFlags = alu;
      Instr    = ins;
      sb_q.push_back({exp, mask});
      nm_q.push_back(nm);
   endtask

   task automatic fetch_decode(input logic [19:0] ins, input int fst);
      for (int i = 0; i < fst; i++)
         emit(1'b0, 1'b0, r4(), ins, v(0,0,0,0,0,1,2'b10,2'b10,2'b00,2'b00,2'b00),
              M_EN|M_ADR|M_SRCA|M_SRCB|M_RES|M_ALU, "fetch_stall");
      emit(1'b0, 1'b1, r4(), ins, v(1,1,0,0,0,1,2'b10,2'b10,2'b00,2'b00,2'b00),
           M_EN|M_ADR|M_SRCA|M_SRCB|M_RES|M_ALU, "fetch");
      emit(1'b0, rb(), r4(), ins, v(0,0,0,0,0,1,2'b10,2'b00,2'b00,2'b00,2'b00),
           M_EN|M_SRCA|M_SRCB|M_ALU, "decode");
   endtask

   // Reference model: one whole instruction, cycle by cycle
   task automatic run_instr(input logic [19:0] ins, input int fst, input int mst,
                            input logic [3:0] exalu);
      logic [1:0] op, aluc;
      logic [5:0] fn;
      logic       c, legal, nowb, rd15;
      op   = ins[15:14];
      fn   = ins[13:8];
      rd15 = (ins[3:0] == 4'hF);
      c    = cond_ok(ins[19:16], m_flags);
      fetch_decode(ins, fst);
      case (op)
         2'b01: begin
            emit(1'b0, rb(), r4(), ins, v(0,0,0,0,0,0,2'b01,2'b00,2'b01,2'b00,2'b00),
                 M_EN|M_SRCA|M_SRCB|M_IMM|M_ALU, "memadr");
            if (fn[0]) begin
               for (int i = 0; i < mst; i++)
                  emit(1'b0, 1'b0, r4(), ins, v(0,0,0,0,1,0,2'b00,2'b00,2'b00,2'b00,2'b00),
                       M_EN|M_ADR, "memread_stall");
               emit(1'b0, 1'b1, r4(), ins, v(0,0,0,0,1,0,2'b00,2'b00,2'b00,2'b00,2'b00),
                    M_EN|M_ADR, "memread");
               emit(1'b0, rb(), r4(), ins, v(0,0,c,0,0,0,2'b00,2'b01,2'b00,2'b00,2'b00),
                    M_EN|M_RES, "memwb");
            end else begin
               for (int i = 0; i < mst; i++)
                  emit(1'b0, 1'b0, r4(), ins, v(0,0,0,c,1,0,2'b00,2'b00,2'b00,2'b10,2'b00),
                       M_EN|M_ADR|M_REG1, "memwrite_stall");
               emit(1'b0, 1'b1, r4(), ins, v(0,0,0,c,1,0,2'b00,2'b00,2'b00,2'b10,2'b00),
                    M_EN|M_ADR|M_REG1, "memwrite");
            end
         end
         2'b10: begin
            emit(1'b0, rb(), r4(), ins, v(c,0,0,0,0,0,2'b01,2'b10,2'b10,2'b01,2'b00),
                 M_EN|M_SRCA|M_SRCB|M_RES|M_IMM|M_REG0|M_ALU, "branch");
         end
         2'b00: begin
            legal = 1'b1;
            nowb  = 1'b0;
            aluc  = 2'b00;
            case (fn[4:1])
               4'b0100: aluc = 2'b00;
               4'b0010: aluc = 2'b01;
               4'b0000: aluc = 2'b10;
               4'b1100: aluc = 2'b11;
               4'b1010, 4'b1011: begin
                  aluc  = fn[1] ? 2'b00 : 2'b01;
                  nowb  = 1'b1;
                  legal = CMP_EN && fn[0];
               end
               default: legal = 1'b0;
            endcase
            if (legal) begin
               if (fn[5])
                  emit(1'b0, rb(), exalu, ins, v(0,0,0,0,0,0,2'b01,2'b00,2'b00,2'b00,aluc),
                       M_EN|M_SRCB|M_IMM|M_ALU, "executei");
               else
                  emit(1'b0, rb(), exalu, ins, v(0,0,0,0,0,0,2'b00,2'b00,2'b00,2'b00,aluc),
                       M_EN|M_SRCA|M_SRCB|M_ALU, "executer");
               if (fn[0] && c) begin
                  m_flags[3:2] = exalu[3:2];
                  if (aluc == 2'b00 || aluc == 2'b01) m_flags[1:0] = exalu[1:0];
               end
               if (!nowb)
                  emit(1'b0, rb(), r4(), ins, v(c & rd15,0,c,0,0,0,2'b00,2'b00,2'b00,2'b00,2'b00),
                       M_EN|M_RES, "aluwb");
            end
         end
         default: ;
      endcase
   endtask

   // STR held in a MemReady stall, interrupted by reset
   task automatic str_with_reset();
      logic [19:0] ins;
      ins = 20'hE5801;
      fetch_decode(ins, 0);
      emit(1'b0, rb(), r4(), ins, v(0,0,0,0,0,0,2'b01,2'b00,2'b01,2'b00,2'b00),
           M_EN|M_SRCA|M_SRCB|M_IMM|M_ALU, "memadr");
      for (int i = 0; i < 2; i++)
         emit(1'b0, 1'b0, r4(), ins, v(0,0,0,1,1,0,2'b00,2'b00,2'b00,2'b10,2'b00),
              M_EN|M_ADR|M_REG1, "memwrite_stall");
      emit(1'b1, 1'b0, r4(), ins, 16'h0000, M_EN, "reset_in_memwrite");
      m_flags = 4'b0000;
   endtask

   function automatic logic [19:0] rand_instr();
      logic [19:0] r;
      r = 20'($urandom);
      if ($urandom_range(0, 2) != 0) r[19:16] = 4'hE;
      case ($urandom_range(0, 9))
         0, 1, 2, 3: begin
            r[15:14] = 2'b00;
            case ($urandom_range(0, 3))
               0:       r[12:9] = 4'b0100;
               1:       r[12:9] = 4'b0010;
               2:       r[12:9] = 4'b0000;
               default: r[12:9] = 4'b1100;
            endcase
         end
         4:       r[15:14] = 2'b00;
         5: begin
            r[15:14] = 2'b00;
            r[12:10] = 3'b101;
            r[8]     = ($urandom_range(0, 3) != 0);
         end
         6, 7:    r[15:14] = 2'b01;
         8:       r[15:14] = 2'b10;
         default: r[15:14] = 2'b11;
      endcase
      if ($urandom_range(0, 3) == 0) r[3:0] = 4'hF;
      return r;
   endfunction

   initial begin
      reset    = 1'b1;
      MemReady = 1'b0;
      ALUFlags = 4'h0;
      Instr    = 20'h0;
      m_flags  = 4'b0000;

      emit(1'b1, 1'b0, 4'h0, 20'h0, 16'h0000, M_EN, "reset");
      emit(1'b1, 1'b1, 4'h0, 20'h0, 16'h0000, M_EN, "reset");

      run_instr(20'hE2801, 0, 0, r4());        // ADD R1,R0,#5
      run_instr(20'hE5901, 1, 3, r4());        // LDR, 3 MemReady-low cycles
      run_instr(20'hE0502, 0, 0, 4'b0110);     // SUBS -> Z=1, C=1
      run_instr(20'h0A000, 0, 0, r4());        // BEQ: taken
      run_instr(20'h1A000, 0, 0, r4());        // BNE: not taken
      str_with_reset();
      run_instr(20'h0A000, 0, 0, r4());        // BEQ after reset: flags cleared
      run_instr(20'hE1500, 0, 0, 4'b0110);     // CMP R0,R0
      run_instr(20'h0A000, 0, 0, r4());        // BEQ observes CMP's Z
      run_instr(20'h2A000, 0, 0, r4());        // BCS observes CMP's C
      run_instr(20'hF0A00, 0, 0, r4());        // never-execute condition

      for (int k = 0; k < 300; k++)
         run_instr(rand_instr(), $urandom_range(0, 2), $urandom_range(0, 3), r4());

      @(posedge clk);
      @(negedge clk);
      #1;
      if (sb_q.size() != 0) begin
         miscompares++;
         $display("FAIL scoreboard: %0d expectations left unchecked", sb_q.size());
      end
      if (vectors < 100) begin
         miscompares++;
         $display("FAIL coverage: only %0d vectors compared", vectors);
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      if (miscompares == 0)
         $display("PASS");
      else
         $display("FAIL %0d miscompares", miscompares);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/arm_mc_controller.md
ARM_MC_CONTROLLER -- requirements
Module: arm_mc_controller

Interface
REQ-001 Parameters: none.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 Instr  input  20  instruction register bits [31:12]: Cond[31:28], Op[27:26], Funct[25:20], Rd[15:12].
REQ-005 ALUFlags  input  4  {N,Z,C,V} from the ALU, current cycle.
REQ-006 MemReady  input  1  shared memory completes the current access this cycle.
REQ-007 PCWrite, IRWrite, RegWrite, MemWrite  output  1 each  write enables.
REQ-008 AdrSrc  output  1  memory address: 0 = PC, 1 = ALUOut.
REQ-009 ALUSrcA  output  1  0 = register A, 1 = PC; ALUSrcB  output  2  00 = WriteData, 01 = ExtImm, 10 = constant 4.
REQ-010 ResultSrc  output  2  00 = ALUOut, 01 = Data, 10 = ALUResult.
REQ-011 ImmSrc  output  2  00 = imm8, 01 = imm12, 10 = branch imm24; RegSrc  output  2  [0] RA1 = R15, [1] RA2 = Rd.
REQ-012 ALUControl  output  2  00 ADD, 01 SUB, 10 AND, 11 ORR.

Function
REQ-013 States: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECUTER, EXECUTEI, ALUWB, BRANCH.
REQ-014 FETCH: AdrSrc=0, ALUSrcA=1, ALUSrcB=10, ADD, ResultSrc=10; IRWrite=PCWrite=MemReady; stay in FETCH while MemReady=0, else go to DECODE.
REQ-015 DECODE: ALUSrcA=1, ALUSrcB=10, ADD (PC+8 formed); CondExR latched from condcheck(Cond, Flags) at the end of the cycle.
REQ-016 DECODE next state: Op=01 -> MEMADR; Op=00 with Funct[5]=0 -> EXECUTER, Funct[5]=1 -> EXECUTEI; Op=10 -> BRANCH; Op=11 -> FETCH, no writes.
REQ-017 MEMADR: ALUSrcA=0, ALUSrcB=01, ImmSrc=01, ADD; Funct[0]=1 -> MEMREAD, else -> MEMWRITE.
REQ-018 MEMREAD: AdrSrc=1; hold until MemReady=1, then -> MEMWB.
REQ-019 MEMWB: ResultSrc=01, RegWrite=CondExR -> FETCH.
REQ-020 MEMWRITE: AdrSrc=1, RegSrc[1]=1, MemWrite=CondExR, held asserted until MemReady=1, then -> FETCH; MemWrite=0 for the whole state when CondExR=0, exit still on MemReady=1.
REQ-021 EXECUTER: ALUSrcA=0, ALUSrcB=00; EXECUTEI: ALUSrcB=01, ImmSrc=00; both -> ALUWB; ALUControl from Funct[4:1]: 0100 ADD, 0010 SUB, 0000 AND, 1100 ORR.
REQ-022 Flags register (4 bits): in EXECUTER/EXECUTEI with S=Funct[0]=1 and CondExR=1, N,Z are loaded always; C,V are loaded only for ADD/SUB.
REQ-023 ALUWB: ResultSrc=00, RegWrite=CondExR; Rd=15 additionally asserts PCWrite=CondExR -> FETCH.
REQ-024 BRANCH: RegSrc[0]=1, ALUSrcA=0, ALUSrcB=01, ImmSrc=10, ADD, ResultSrc=10, PCWrite=CondExR -> FETCH.
REQ-025 Unused Funct[4:1] codes in Op=00: DECODE -> FETCH, no writes, no flag update.
REQ-026 Condition evaluation uses flags as of DECODE; a flag update in EXECUTE does not affect the same instruction's writeback.
REQ-027 Cond=1111: CondExR=0.

Reset
REQ-028 reset=1 at any clock edge, including mid-instruction or during a MemReady stall: state=FETCH, Flags=0000, CondExR=0.
REQ-029 While reset=1: PCWrite, IRWrite, RegWrite, MemWrite = 0.

Configuration
REQ-030 Macro ARM_MC_CMP_EN defined: Funct[4:1]=1010 (CMP, SUB) and 1011 (CMN, ADD) with S=1 execute, update all four flags if CondExR=1, then go EXECUTE -> FETCH with no ALUWB and no register write.
REQ-031 Macro undefined: these encodings follow REQ-025.

Verification
REQ-032 ADD R1,R0,#5 (0xE2801005) with MemReady=1 -> FETCH, DECODE, EXECUTEI, ALUWB; RegWrite=1 only in ALUWB; 4 cycles.
REQ-033 LDR with MemReady low 3 cycles in MEMREAD -> MEMREAD held 4 cycles; AdrSrc=1 throughout; RegWrite=1 once in MEMWB.
REQ-034 SUBS result 0, then BEQ -> Flags Z=1; BRANCH asserts PCWrite=1; same with BNE -> PCWrite=0 in BRANCH.
REQ-035 reset pulsed during MEMWRITE stall -> next cycle FETCH, MemWrite=0, Flags=0000.
REQ-036 CMP R0,R0 (0xE1500000) -> with ARM_MC_CMP_EN: Z=1, C=1, no RegWrite, 3 cycles; without: no flag change, 2 cycles.
